// File: rtl/keypad_scanner.sv
// keypad_scanner: autonomous 4x4 keypad scan controller with frame debouncing,
// a small key-code FIFO and a Wishbone register interface.
module keypad_scanner #(
   parameter logic [15:0] SETTLE   = 16'd1000,
   parameter logic [2:0]  DEBOUNCE = 3'd3,
   parameter int          LGFIFO   = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic        i_wb_addr,
   input  logic [31:0] i_wb_data,
   output logic        o_wb_ack,
   output logic        o_wb_stall,
   output logic [31:0] o_wb_data,
   output logic [3:0]  o_kp_col,
   input  logic [3:0]  i_kp_row,
   output logic        o_int
);
   localparam int DEPTH = 1 << LGFIFO;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_DRIVE  = 3'd1;
   localparam logic [2:0] S_SAMPLE = 3'd2;
   localparam logic [2:0] S_EVAL   = 3'd3;
   localparam logic [2:0] S_PUSH   = 3'd4;

   logic [3:0]      row_meta_q, row_sync_q;
   logic [2:0]      state_q, state_d;
   logic [1:0]      col_q, col_d;
   logic [15:0]     cnt_q, cnt_d;
   logic [3:0]      kp_col_q, kp_col_d;
   logic [15:0]     frame_q, frame_d;
   logic [15:0]     prev_frame_q, prev_frame_d;
   logic [15:0]     debounced_q, debounced_d;
   logic [15:0]     newkeys_q, newkeys_d;
   logic [2:0]      stable_q, stable_d, stable_inc;
   logic [3:0]      idx_q, idx_d;
   logic            enable_q, enable_d;
   logic            overflow_q, overflow_d;
   logic [LGFIFO:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LGFIFO:0] fill_q, fill_d;
   logic [3:0]      mem_q [DEPTH];
   logic [2:0]      fill3;
   logic            push, push_ok, pop, flush, full, empty;
   logic            wb_req, wb_rd0, wb_wr0, wb_rd1, wb_wr1;
   logic            ack_q;
   logic [31:0]     rdata_q, rdata_d;
   logic            int_q;
   logic            unused_wb;

   assign unused_wb = ^i_wb_data[30:2];

   assign wb_req = i_wb_cyc & i_wb_stb;
   assign wb_rd0 = wb_req & ~i_wb_we & ~i_wb_addr;
   assign wb_wr0 = wb_req &  i_wb_we & ~i_wb_addr;
   assign wb_rd1 = wb_req & ~i_wb_we &  i_wb_addr;
   assign wb_wr1 = wb_req &  i_wb_we &  i_wb_addr;

   assign fill_q = wr_ptr_q - rd_ptr_q;
   assign fill3  = 3'(fill_q);
   assign full   = (fill_q == (LGFIFO+1)'(DEPTH));
   assign empty  = (fill_q == '0);
   assign pop    = wb_rd0 & ~empty;
   assign flush  = wb_wr0 & i_wb_data[31];

   // Scan sequencer: column walk, frame capture, debounce and new-key push
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      cnt_d        = cnt_q;
      kp_col_d     = kp_col_q;
      frame_d      = frame_q;
      prev_frame_d = prev_frame_q;
      debounced_d  = debounced_q;
      newkeys_d    = newkeys_q;
      stable_d     = stable_q;
      idx_d        = idx_q;
      push         = 1'b0;
      stable_inc   = (stable_q >= DEBOUNCE) ? DEBOUNCE : stable_q + 3'd1;
      // Disabling aborts a scan in progress; an ongoing push sequence completes.
      if (!enable_d && (state_q == S_DRIVE || state_q == S_SAMPLE || state_q == S_EVAL)) begin
         state_d  = S_IDLE;
         col_d    = 2'd0;
         kp_col_d = 4'hf;
         frame_d  = 16'h0;
         stable_d = 3'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               kp_col_d = 4'hf;
               if (enable_d) begin
                  state_d  = S_DRIVE;
                  col_d    = 2'd0;
                  kp_col_d = 4'he;
                  cnt_d    = SETTLE - 16'd1;
               end
            end
            S_DRIVE: begin
               if (cnt_q == 16'd0) state_d = S_SAMPLE;
               else                cnt_d   = cnt_q - 16'd1;
            end
            S_SAMPLE: begin
               frame_d[{col_q, 2'b00} +: 4] = ~row_sync_q;
               if (col_q != 2'd3) begin
                  col_d    = col_q + 2'd1;
                  kp_col_d = ~(4'h1 << (col_q + 2'd1));
                  cnt_d    = SETTLE - 16'd1;
                  state_d  = S_DRIVE;
               end else begin
                  kp_col_d = 4'hf;
                  state_d  = S_EVAL;
               end
            end
            S_EVAL: begin
               stable_d     = (frame_q == prev_frame_q) ? stable_inc : 3'd0;
               prev_frame_d = frame_q;
               state_d      = S_IDLE;
               if (stable_d == DEBOUNCE) begin
                  newkeys_d   = frame_q & ~debounced_q;
                  debounced_d = frame_q;
                  if ((frame_q & ~debounced_q) != 16'h0) begin
                     state_d = S_PUSH;
                     idx_d   = 4'd0;
                  end
               end
            end
            S_PUSH: begin
               push  = newkeys_q[idx_q];
               idx_d = idx_q + 4'd1;
               if (idx_q == 4'd15) state_d = S_IDLE;
            end
            default: begin
               state_d  = S_IDLE;
               kp_col_d = 4'hf;
            end
         endcase
      end
   end

   // FIFO pointers, enable/overflow control and registered read data
   always_comb begin
      push_ok  = push & (~full | pop) & ~flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      end
      fill_d = wr_ptr_d - rd_ptr_d;

      enable_d = wb_wr1 ? i_wb_data[0] : enable_q;

      overflow_d = overflow_q;
      if (wb_wr1 && i_wb_data[1])            overflow_d = 1'b0;
      if (push && full && !pop && !flush)    overflow_d = 1'b1;

      rdata_d = rdata_q;
      if (wb_rd0)
         rdata_d = {21'h0, fill3, 3'b000, ~empty,
                    empty ? 4'h0 : mem_q[rd_ptr_q[LGFIFO-1:0]]};
      else if (wb_rd1)
         rdata_d = {29'h0, |debounced_q, overflow_q, enable_q};
   end

   // Key-code storage; contents are don't-care while the pointers say empty
   always_ff @(posedge i_clk) begin
      if (push_ok) mem_q[wr_ptr_q[LGFIFO-1:0]] <= idx_q;
   end

   // State registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         row_meta_q   <= 4'hf;
         row_sync_q   <= 4'hf;
         state_q      <= S_IDLE;
         col_q        <= 2'd0;
         cnt_q        <= 16'd0;
         kp_col_q     <= 4'hf;
         frame_q      <= 16'h0;
         prev_frame_q <= 16'h0;
         debounced_q  <= 16'h0;
         newkeys_q    <= 16'h0;
         stable_q     <= 3'd0;
         idx_q        <= 4'd0;
         enable_q     <= 1'b1;
         overflow_q   <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         ack_q        <= 1'b0;
         rdata_q      <= 32'h0;
         int_q        <= 1'b0;
      end else begin
         row_meta_q   <= i_kp_row;
         row_sync_q   <= row_meta_q;
         state_q      <= state_d;
         col_q        <= col_d;
         cnt_q        <= cnt_d;
         kp_col_q     <= kp_col_d;
         frame_q      <= frame_d;
         prev_frame_q <= prev_frame_d;
         debounced_q  <= debounced_d;
         newkeys_q    <= newkeys_d;
         stable_q     <= stable_d;
         idx_q        <= idx_d;
         enable_q     <= enable_d;
         overflow_q   <= overflow_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         ack_q        <= wb_req;
         rdata_q      <= rdata_d;
         int_q        <= (fill_d != '0);
      end
   end

   assign o_wb_ack   = ack_q;
   assign o_wb_stall = 1'b0;
   assign o_wb_data  = rdata_q;
   assign o_kp_col   = kp_col_q;
   assign o_int      = int_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: bus reads queue their expected word,
// a monitor pops and compares on every ack; a keypad model drives the rows.
module tb_keypad_scanner;
   logic        clk = 1'b0;
   logic        rst;
   logic        cyc, stb, we, adr;
   logic [31:0] dat;
   logic        ack, stall, irq;
   logic [31:0] rdat;
   logic [3:0]  kp_col, kp_row;
   logic [15:0] pressed;

   typedef struct {
      logic        chk;
      logic [31:0] val;
      string       name;
   } exp_t;
   exp_t sbq[$];

   int n_pass  = 0;
   int n_total = 0;
   int k;

   always #5 clk = ~clk;

   keypad_scanner #(.SETTLE(16'd4), .DEBOUNCE(3'd2), .LGFIFO(2)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(adr),
      .i_wb_data(dat), .o_wb_ack(ack), .o_wb_stall(stall), .o_wb_data(rdat),
      .o_kp_col(kp_col), .i_kp_row(kp_row), .o_int(irq)
   );

   // Keypad model: a pressed key pulls its row low while its column is driven
   always_comb begin
      kp_row = 4'hf;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (!kp_col[c] && pressed[4*c+r]) kp_row[r] = 1'b0;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, expv);
   endtask

   task automatic wb_read(input logic a, input logic [31:0] expv, input string nm);
      exp_t e;
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; dat = 32'h0;
      e.chk = 1'b1; e.val = expv; e.name = nm;
      sbq.push_back(e);
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0;
   endtask

   task automatic wb_write(input logic a, input logic [31:0] d);
      exp_t e;
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat = d;
      e.chk = 1'b0; e.val = 32'h0; e.name = "write";
      sbq.push_back(e);
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   // Returns at the negedge inside the n-th EVAL cycle (column 3 -> all high)
   task automatic wait_evals(input int n);
      int seen = 0;
      int cnt  = 0;
      logic [3:0] prev = kp_col;
      while (seen < n && cnt < 3000) begin
         @(negedge clk);
         cnt++;
         if (prev == 4'h7 && kp_col == 4'hf) seen++;
         prev = kp_col;
      end
      if (seen < n) check("eval_timeout", 32'(seen), 32'(n));
   endtask

   task automatic settle_push();
      wait_evals(3);
      repeat (20) @(posedge clk);
      @(negedge clk);
   endtask

   // Monitor: every ack consumes one scoreboard entry
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (ack) begin
            if (sbq.size() == 0) check("unexpected_ack", 32'h1, 32'h0);
            else begin
               e = sbq.pop_front();
               if (e.chk) check(e.name, rdat, e.val);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] wexp;
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 1'b0; dat = 32'h0;
      pressed = 16'h0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state and column walk
      @(negedge clk);
      check("reset_col", 32'(kp_col), 32'hf);
      check("reset_int", 32'(irq), 32'h0);
      check("reset_ack", 32'(ack), 32'h0);
      check("reset_data", rdat, 32'h0);
      check("stall", 32'(stall), 32'h0);
      for (int i = 0; i < 23; i++) begin
         @(negedge clk);
         wexp = (i < 5) ? 4'he : (i < 10) ? 4'hd : (i < 15) ? 4'hb :
                (i < 20) ? 4'h7 : (i < 22) ? 4'hf : 4'he;
         check("col_walk", 32'(kp_col), 32'(wexp));
      end

      // Single key at column 1 / row 2
      wait_evals(1);
      pressed[6] = 1'b1;
      settle_push();
      check("int_after_push", 32'(irq), 32'h1);
      wb_read(1'b1, 32'h5, "reg1_held");
      wb_read(1'b0, 32'h116, "pop_code6");
      @(negedge clk);
      check("int_after_pop", 32'(irq), 32'h0);
      wb_read(1'b0, 32'h0, "empty_after6");
      wait_evals(1);
      pressed[6] = 1'b0;
      wait_evals(3);
      wb_read(1'b1, 32'h1, "reg1_release6");

      // Bouncing row 0 never debounces, then held steady pushes once
      for (int i = 0; i < 5; i++) begin
         wait_evals(1);
         pressed[0] = ~pressed[0];
      end
      wb_read(1'b0, 32'h0, "bounce_no_push");
      settle_push();
      wb_read(1'b0, 32'h110, "pop_code0");
      wb_read(1'b0, 32'h0, "code0_once");
      wait_evals(1);
      pressed[0] = 1'b0;
      settle_push();
      wb_read(1'b1, 32'h1, "reg1_release0");
      wb_read(1'b0, 32'h0, "release_no_push");

      // Three simultaneous keys come out in index order
      wait_evals(1);
      pressed[3] = 1'b1; pressed[9] = 1'b1; pressed[12] = 1'b1;
      settle_push();
      wb_read(1'b0, 32'h313, "pop_code3");
      wb_read(1'b0, 32'h219, "pop_code9");
      wb_read(1'b0, 32'h11c, "pop_code12");

      // Five new keys into a four-entry FIFO
      wait_evals(1);
      pressed[0] = 1'b1; pressed[1] = 1'b1; pressed[5] = 1'b1;
      pressed[10] = 1'b1; pressed[15] = 1'b1;
      settle_push();
      check("int_full", 32'(irq), 32'h1);
      wb_read(1'b1, 32'h7, "reg1_overflow");
      wb_write(1'b1, 32'h2);
      wb_read(1'b1, 32'h4, "reg1_ovf_cleared");
      wb_write(1'b1, 32'h1);

      // Pop on the same cycle as a push into the full FIFO (push at idx 2)
      wait_evals(1);
      pressed[2] = 1'b1;
      wait_evals(3);
      @(posedge clk);
      @(posedge clk);
      wb_read(1'b0, 32'h410, "pop_during_push");
      wb_read(1'b1, 32'h5, "reg1_no_ovf");
      wb_read(1'b0, 32'h411, "drain_code1");
      wb_read(1'b0, 32'h315, "drain_code5");
      wb_read(1'b0, 32'h21a, "drain_code10");
      wb_read(1'b0, 32'h112, "drain_code2");
      wb_read(1'b0, 32'h0, "empty_read");
      wb_read(1'b1, 32'h5, "reg1_unchanged");
      @(negedge clk);
      check("int_drained", 32'(irq), 32'h0);

      // Clear enable mid-DRIVE with a press one frame from acceptance
      wait_evals(1);
      pressed[7] = 1'b1; pressed[14] = 1'b1;
      wait_evals(2);
      k = 0;
      while (kp_col != 4'hd && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("reach_col1", 32'(kp_col), 32'hd);
      wb_write(1'b1, 32'h0);
      @(negedge clk);
      check("disable_col", 32'(kp_col), 32'hf);
      repeat (60) @(negedge clk);
      check("disabled_col", 32'(kp_col), 32'hf);
      check("disabled_int", 32'(irq), 32'h0);
      wb_read(1'b0, 32'h0, "disabled_no_push");

      // Re-enable; reset in the middle of the resulting push sequence
      wb_write(1'b1, 32'h1);
      wait_evals(2);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("int_mid_push", 32'(irq), 32'h1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rst2_col", 32'(kp_col), 32'hf);
      check("rst2_int", 32'(irq), 32'h0);
      check("rst2_ack", 32'(ack), 32'h0);
      check("rst2_data", rdat, 32'h0);
      wb_read(1'b1, 32'h1, "rst2_reg1");
      wb_read(1'b0, 32'h0, "rst2_fifo_empty");

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(sbq.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
